// File: rtl/mux4_rr_arbiter_if.sv
// Bundle of the requester-side and downstream-side signals of the 4:1 arbitrated mux.
// Handshake: a beat moves downstream on every rising clk edge where out_valid and
// out_ready are both high; out_valid never waits on out_ready, and while out_valid
// is high and out_ready is low, out_data/out_last/sel stay unchanged.
interface mux4_rr_arbiter_if #(
    parameter int DW = 8
);
    logic [3:0]      req;
    logic [4*DW-1:0] data_in;
    logic [3:0]      last;
    logic            out_ready;
    logic [3:0]      grant;
    logic [1:0]      sel;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_last;

    // Requesters plus downstream sink: drive the inputs and observe the results.
    modport master (
        output req, data_in, last, out_ready,
        input  grant, sel, out_data, out_valid, out_last
    );

    // The arbiter itself.
    modport slave (
        input  req, data_in, last, out_ready,
        output grant, sel, out_data, out_valid, out_last
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing one downstream port. A grant is
// held until end-of-packet, MAX_HOLD beats, or the owner dropping its request,
// followed by one idle cycle before the next pick.
module mux4_rr_arbiter #(
    parameter int DW       = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux4_rr_arbiter_if.slave     bus,
    output logic                 dbg_state,
    output logic [1:0]           dbg_ptr,
    output logic [3:0]           dbg_cnt
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_next;
    logic [3:0]    grant_q, grant_next;
    logic [1:0]    sel_q, sel_next;
    logic [1:0]    ptr, ptr_next;
    logic [3:0]    cnt, cnt_next;

    logic [DW-1:0] lane [4];
    logic [1:0]    win;
    logic [1:0]    idx;
    logic          xfer;
    logic          hold_done;
    logic          release_now;

    // Split the packed data bus into per-lane words.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane[i] = bus.data_in[i*DW +: DW];
        end
    end

    // Winner search starting at ptr; descending loop leaves the nearest set bit.
    always_comb begin
        win = ptr;
        idx = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (bus.req[idx]) begin
                win = idx;
            end
        end
    end

    // Downstream-facing outputs are combinational off the registered select.
    always_comb begin
        bus.grant     = grant_q;
        bus.sel       = sel_q;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.out_data  = '0;
        if (state == GRANT) begin
            bus.out_valid = bus.req[sel_q];
            bus.out_last  = bus.last[sel_q] & bus.req[sel_q];
            bus.out_data  = lane[sel_q];
        end
    end

    assign xfer        = bus.out_valid & bus.out_ready;
    assign hold_done   = (cnt + 4'd1) >= 4'(MAX_HOLD);
    assign release_now = (xfer & (bus.out_last | hold_done)) | ~bus.req[sel_q];

    // Next-state logic: pick in IDLE, count and release in GRANT.
    always_comb begin
        state_next = state;
        grant_next = grant_q;
        sel_next   = sel_q;
        ptr_next   = ptr;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (bus.req != 4'b0000) begin
                    state_next = GRANT;
                    sel_next   = win;
                    grant_next = 4'b0001 << win;
                    cnt_next   = 4'd0;
                end
            end
            GRANT: begin
                if (xfer) begin
                    cnt_next = hold_done ? 4'(MAX_HOLD) : cnt + 4'd1;
                end
                if (release_now) begin
                    state_next = IDLE;
                    grant_next = 4'b0000;
                    ptr_next   = sel_q + 2'd1;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = 4'b0000;
            end
        endcase
    end

    // State register; reset aborts any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant_q <= 4'b0000;
            sel_q   <= 2'd0;
            ptr     <= 2'd0;
            cnt     <= 4'd0;
        end else begin
            state   <= state_next;
            grant_q <= grant_next;
            sel_q   <= sel_next;
            ptr     <= ptr_next;
            cnt     <= cnt_next;
        end
    end

    assign dbg_state = (state == GRANT);
    assign dbg_ptr   = ptr;
    assign dbg_cnt   = cnt;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios plus random traffic, all checked
// against a lane-index reference model of the arbitration rules.
module tb_mux4_rr_arbiter;
    localparam int DW       = 8;
    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic       dbg_state;
    logic [1:0] dbg_ptr;
    logic [3:0] dbg_cnt;

    int n_checks;
    int n_fail;

    // reference model: granted lane index or -1 when idle
    int m_lane;
    int m_ptr;
    int m_sel;
    int m_cnt;

    mux4_rr_arbiter_if #(.DW(DW)) bus ();

    mux4_rr_arbiter #(.DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .dbg_state (dbg_state),
        .dbg_ptr   (dbg_ptr),
        .dbg_cnt   (dbg_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lane = -1;
        m_ptr  = 0;
        m_sel  = 0;
        m_cnt  = 0;
    endtask

    task automatic model_release();
        m_ptr  = (m_lane + 1) % 4;
        m_lane = -1;
    endtask

    // advance the model by one clock edge using the inputs currently applied
    task automatic model_update();
        int found;
        found = -1;
        if (m_lane < 0) begin
            for (int k = 0; k < 4; k++) begin
                if (found < 0 && bus.req[(m_ptr + k) % 4]) found = (m_ptr + k) % 4;
            end
            if (found >= 0) begin
                m_lane = found;
                m_sel  = found;
                m_cnt  = 0;
            end
        end else if (!bus.req[m_lane]) begin
            model_release();
        end else if (bus.out_ready) begin
            m_cnt = m_cnt + 1;
            if (bus.last[m_lane] || m_cnt >= MAX_HOLD) model_release();
        end
    endtask

    // compare all observable outputs with what the model predicts now
    task automatic compare_model();
        logic [3:0]  e_grant;
        logic        e_valid;
        logic [7:0]  e_data;
        logic        e_last;
        e_grant = 4'b0000;
        e_valid = 1'b0;
        e_data  = 8'h00;
        e_last  = 1'b0;
        if (m_lane >= 0) begin
            e_grant = 4'(1 << m_lane);
            e_valid = bus.req[m_lane];
            e_data  = 8'((bus.data_in >> (DW * m_lane)) & 32'hFF);
            e_last  = e_valid & bus.last[m_lane];
        end
        check("grant",     32'(bus.grant),     32'(e_grant));
        check("sel",       32'(bus.sel),       32'(m_sel));
        check("out_valid", 32'(bus.out_valid), 32'(e_valid));
        check("out_data",  32'(bus.out_data),  32'(e_data));
        check("out_last",  32'(bus.out_last),  32'(e_last));
        check("ptr",       32'(dbg_ptr),       32'(m_ptr));
    endtask

    // driver tasks
    task automatic drive(input logic [3:0] r, input logic [31:0] d, input logic [3:0] l, input logic rdy);
        bus.req       = r;
        bus.data_in   = d;
        bus.last      = l;
        bus.out_ready = rdy;
    endtask

    // outputs already checked mid-cycle; compare model, cross the edge, settle
    task automatic tick();
        compare_model();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step(input logic [3:0] r, input logic [31:0] d, input logic [3:0] l, input logic rdy);
        drive(r, d, l, rdy);
        #4;
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [3:0] rr_seq [10];
    logic [3:0] hold_seq [12];
    logic [7:0] held_data;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        rst_n = 1'b0;
        drive(4'b1111, 32'h44332211, 4'b0000, 1'b1);

        // reset held with all lanes requesting
        for (int i = 0; i < 3; i++) begin
            #4;
            check("rst_grant", 32'(bus.grant),     32'h0);
            check("rst_valid", 32'(bus.out_valid), 32'h0);
            check("rst_data",  32'(bus.out_data),  32'h0);
            @(posedge clk);
            #1;
        end
        drive(4'b0000, 32'h0, 4'b0000, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(4'b0000, 32'h0, 4'b0000, 1'b1);
        check("idle_grant", 32'(bus.grant), 32'h0);

        // basic grant of lane 2
        drive(4'b0100, 32'h00A50000, 4'b0100, 1'b1);
        #4;
        check("basic_pre_grant", 32'(bus.grant), 32'h0);
        tick();
        #4;
        check("basic_grant", 32'(bus.grant),     32'h4);
        check("basic_sel",   32'(bus.sel),       32'h2);
        check("basic_valid", 32'(bus.out_valid), 32'h1);
        check("basic_data",  32'(bus.out_data),  32'hA5);
        check("basic_last",  32'(bus.out_last),  32'h1);
        tick();
        drive(4'b0000, 32'h0, 4'b0000, 1'b1);
        #4;
        check("basic_release", 32'(bus.grant), 32'h0);
        check("basic_ptr",     32'(dbg_ptr),   32'h3);
        tick();

        // round-robin fairness from ptr=0
        do_reset();
        rr_seq = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
        for (int i = 0; i < 10; i++) begin
            drive(4'b1111, $urandom, 4'b1111, 1'b1);
            #4;
            check("rr_seq", 32'(bus.grant), 32'(rr_seq[i]));
            tick();
        end

        // hold limit with two requesters and no end-of-packet
        do_reset();
        hold_seq = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h1};
        for (int i = 0; i < 12; i++) begin
            drive(4'b0011, $urandom, 4'b0000, 1'b1);
            #4;
            check("hold_seq", 32'(bus.grant), 32'(hold_seq[i]));
            tick();
        end
        step(4'b0000, 32'h0, 4'b0000, 1'b1);
        step(4'b0000, 32'h0, 4'b0000, 1'b1);

        // backpressure on lane 1
        step(4'b0010, 32'h0000C300, 4'b0010, 1'b0);
        held_data = bus.out_data;
        for (int i = 0; i < 5; i++) begin
            drive(4'b0010, 32'h0000C300, 4'b0010, 1'b0);
            #4;
            check("bp_valid", 32'(bus.out_valid), 32'h1);
            check("bp_data",  32'(bus.out_data),  32'hC3);
            check("bp_cnt",   32'(dbg_cnt),       32'h0);
            check("bp_grant", 32'(bus.grant),     32'h2);
            tick();
        end
        check("bp_data_stable", 32'(held_data), 32'hC3);
        step(4'b0010, 32'h0000C300, 4'b0010, 1'b1);
        drive(4'b0000, 32'h0, 4'b0000, 1'b1);
        #4;
        check("bp_release", 32'(bus.grant), 32'h0);
        tick();

        // lane 3 drops its request mid-grant
        step(4'b1000, 32'h77000000, 4'b0000, 1'b1);
        drive(4'b0000, 32'h77000000, 4'b0000, 1'b1);
        #4;
        check("drop_valid", 32'(bus.out_valid), 32'h0);
        check("drop_grant", 32'(bus.grant),     32'h8);
        tick();
        drive(4'b0000, 32'h0, 4'b0000, 1'b1);
        #4;
        check("drop_released", 32'(bus.grant), 32'h0);
        check("drop_ptr",      32'(dbg_ptr),   32'h0);
        tick();

        // reset in the middle of a lane 2 packet
        step(4'b0100, 32'h00550000, 4'b0000, 1'b1);
        drive(4'b0100, 32'h00550000, 4'b0000, 1'b1);
        #2;
        check("pre_rst_grant", 32'(bus.grant), 32'h4);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_grant", 32'(bus.grant),     32'h0);
        check("mid_rst_valid", 32'(bus.out_valid), 32'h0);
        check("mid_rst_ptr",   32'(dbg_ptr),       32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step(4'($urandom_range(0, 15)), $urandom,
                 ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
                 ($urandom_range(0, 3) != 0));
        end
        // random traffic with sticky requests so hold limits are reached
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'b1111, $urandom,
                 ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
                 ($urandom_range(0, 2) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter and sequencer for a 4:1 data mux shared by four requesters. Picks one requester and drives the mux select. Forwards that requester's data beats to one downstream port with a valid/ready handshake. Releases the grant on end-of-packet, hold-limit expiry or request drop.

Parameters:
DW, 8, data width per requester lane
MAX_HOLD, 4, max beats transferred per grant (range 1..15)

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
req  input  4  per-requester request; req[i] high means lane i has a valid beat
data_in  input  4*DW  lane i occupies bits [i*DW +: DW]
last  input  4  last[i] marks final beat of lane i's packet
out_ready  input  1  downstream accepts beat this cycle
grant  output  4  one-hot registered grant; all zero when idle
sel  output  2  registered mux select, the index of the granted lane
out_data  output  DW  data_in lane sel while granted, else 0
out_valid  output  1  beat valid toward downstream
out_last  output  1  last[sel] while out_valid, else 0

Behaviour:
- Reset, asynchronous on rst_n low: state=IDLE, grant=0, sel=0, rr pointer ptr=0, beat counter cnt=0. Outputs: out_valid=0, out_last=0, out_data=0. Reset mid-grant aborts the packet immediately, with no partial beat completion.
- FSM states: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, at the clock edge pick the first set req bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Register sel=winner and grant=one-hot(winner), clear cnt, go to GRANT.
  - Request-to-grant latency is exactly 1 cycle.
- GRANT, combinational outputs:
  - out_valid = req[sel]
  - out_data = data_in lane sel
  - out_last = last[sel] & req[sel]
- Transfer: occurs on a cycle with out_valid & out_ready. cnt increments by 1 per transfer and saturates at MAX_HOLD.
- Release, evaluated at the clock edge while in GRANT:
  - (a) transfer with out_last=1, or
  - (b) transfer that makes cnt reach MAX_HOLD, or
  - (c) req[sel]=0, i.e. requester dropped (no transfer that cycle).
  - On release: grant=0, ptr=sel+1 mod 4 (wrap 3->0), state=IDLE. sel holds its value.
- One mandatory IDLE bubble between grants. Next grant appears 2 cycles after the releasing edge's cycle.
- Backpressure: out_ready=0 while out_valid=1 means no transfer. State, cnt and grant hold. out_data must remain lane sel.
- Simultaneous (a) and (b) on the same beat: single release, ptr advances once.
- Non-granted lanes' req/last/data are ignored while in GRANT. Grant never changes mid-packet except by release or reset.
- At most one grant bit high at any time. grant nonzero iff state==GRANT.
- MAX_HOLD=1: every transfer releases.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles with req=4'b1111 -> grant=0, out_valid=0, out_data=0. Release rst_n with req=0 -> grant stays 0.
- Basic grant: req=4'b0100, lane2 data=8'hA5, last[2]=1, out_ready=1 -> next cycle grant=4'b0100, sel=2, out_valid=1, out_data=8'hA5, out_last=1. Following cycle grant=0, ptr=3.
- Round-robin fairness: req=4'b1111 held, every beat last=1, out_ready=1 -> grant sequence 0001, (idle), 0010, (idle), 0100, (idle), 1000, (idle), 0001 (wrap).
- Hold limit: MAX_HOLD=4, req=4'b0011, last=0, out_ready=1 -> lane0 granted for exactly 4 transfers, then IDLE, then lane1 granted. Lane0 gets grant again only after lane1 releases.
- Backpressure: lane1 granted, out_ready=0 for 5 cycles -> out_valid=1, out_data stable, cnt unchanged. out_ready=1 with last[1]=1 -> one transfer, release.
- Drop and reset mid-grant: lane3 granted, deassert req[3] -> out_valid=0 that cycle, grant=0 next edge, ptr=0. Regrant lane2, pulse rst_n low mid-packet -> grant=0 and out_valid=0 immediately, ptr=0.
